// File: rtl/apb_slave_pkg.sv
// -----------------------------------------------------------------------------
// apb_slave_pkg
//   Shared types and helpers for the APB completer register file.
//   - apb_slv_state_t : completer FSM state encoding
//   - ADDR_LSB        : byte-address bit where the word index starts
//   - addr_err()      : flags misaligned or out-of-range byte addresses
// -----------------------------------------------------------------------------
package apb_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_slv_state_t;

    localparam int ADDR_LSB = 2;

    // The address is zero-extended to 64 bits by the caller so that one
    // function serves any PADDR width up to 64.
    function automatic logic addr_err(input logic [63:0] paddr,
                                      input int unsigned num_regs);
        logic [63:0] limit;
        limit = 64'(num_regs) << ADDR_LSB;
        return (paddr[ADDR_LSB-1:0] != '0) || (paddr >= limit);
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile_if
//   APB bus bundle between a requester (master) and the register-file
//   completer (slave).
//   Requester drives : i_psel, i_penable, i_pwrite, i_paddr, i_pwdata
//   Completer drives : o_prdata, o_pready, o_pslverr
//
//   Handshake: a transfer starts with one setup cycle (i_psel=1,
//   i_penable=0) followed by access cycles (i_psel=1, i_penable=1). The
//   requester must hold address, direction and write data stable through
//   the access phase. The transfer completes on the rising edge where
//   i_psel & i_penable & o_pready are all high; o_prdata and o_pslverr are
//   meaningful only in that cycle. Dropping i_psel before completion aborts
//   the transfer.
// -----------------------------------------------------------------------------
interface apb_slave_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_psel;
    logic                  i_penable;
    logic                  i_pwrite;
    logic [ADDR_WIDTH-1:0] i_paddr;
    logic [DATA_WIDTH-1:0] i_pwdata;
    logic [DATA_WIDTH-1:0] o_prdata;
    logic                  o_pready;
    logic                  o_pslverr;

    modport master (
        output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
        input  o_prdata, o_pready, o_pslverr
    );

    modport slave (
        input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
        output o_prdata, o_pready, o_pslverr
    );
endinterface

// File: rtl/apb_slave_regs.sv
// -----------------------------------------------------------------------------
// apb_slave_regs
//   NUM_REGS x DATA_WIDTH register storage.
//   clk, rst      : clock, asynchronous active-high reset (clears to 0)
//   we/widx/wdata : synchronous write port
//   ridx/rdata    : asynchronous read port
// -----------------------------------------------------------------------------
module apb_slave_regs #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
//   APB completer with a word-addressed register array and a fixed number
//   of wait states per transfer. Misaligned or out-of-range addresses
//   complete with o_pslverr and leave the registers untouched.
//   i_clk_apb   : APB clock, rising edge
//   i_rst_apb   : asynchronous active-high reset
//   apb         : APB bus (slave modport)
//   o_dbg_state : current FSM state, for observation only
// -----------------------------------------------------------------------------
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 i_clk_apb,
    input  logic                 i_rst_apb,
    apb_slave_regfile_if.slave   apb,
    output apb_slv_state_t       o_dbg_state
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    apb_slv_state_t        state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  err_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pready_q;
    logic                  pslverr_q;

    // Decode of the live bus address; only sampled on the setup cycle.
    logic [IDX_W-1:0]      idx_d;
    logic                  err_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  reg_we;

    assign idx_d = apb.i_paddr[ADDR_LSB +: IDX_W];
    assign err_d = addr_err(64'(apb.i_paddr), NUM_REGS);

    // The write commits on the completion edge, so an abort or reset before
    // completion never reaches the array.
    assign reg_we = (state_q == ST_RESP) && apb.i_psel && apb.i_penable &&
                    pready_q && write_q && !err_q;

    apb_slave_regs #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_regs (
        .clk   (i_clk_apb),
        .rst   (i_rst_apb),
        .we    (reg_we),
        .widx  (idx_q),
        .wdata (wdata_q),
        .ridx  (idx_d),
        .rdata (rd_data)
    );

    always_ff @(posedge i_clk_apb or posedge i_rst_apb) begin
        if (i_rst_apb) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // An access cycle without a preceding setup is ignored.
                    if (apb.i_psel && !apb.i_penable) begin
                        idx_q    <= idx_d;
                        err_q    <= err_d;
                        write_q  <= apb.i_pwrite;
                        wdata_q  <= apb.i_pwdata;
                        cnt_q    <= CNT_W'(WAIT_CYCLES);
                        prdata_q <= (!apb.i_pwrite && !err_d) ? rd_data : '0;
                        if (WAIT_CYCLES == 0) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= err_d;
                            state_q   <= ST_RESP;
                        end else begin
                            state_q   <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!apb.i_psel) begin
                        prdata_q  <= '0;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (apb.i_penable) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        // Raising pready here makes it visible in the Nth
                        // access cycle's successor, i.e. after N low cycles.
                        if (cnt_q == CNT_W'(1)) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= err_q;
                            state_q   <= ST_RESP;
                        end
                    end
                end

                ST_RESP: begin
                    if (!apb.i_psel) begin
                        prdata_q  <= '0;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (apb.i_penable && pready_q) begin
                        prdata_q  <= '0;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end

                default: begin
                    prdata_q  <= '0;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign apb.o_prdata  = prdata_q;
    assign apb.o_pready  = pready_q;
    assign apb.o_pslverr = pslverr_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regfile
//   Two completers share one set of bus drivers: dut0 with no wait states,
//   dut1 with three. The cur selector routes psel and the response signals.
// -----------------------------------------------------------------------------
module tb_apb_slave_regfile;
    import apb_slave_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- bus drivers ----------------
    logic        d_psel;
    logic        d_penable;
    logic        d_pwrite;
    logic [31:0] d_paddr;
    logic [31:0] d_pwdata;
    int          cur;

    apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    apb_slv_state_t st0;
    apb_slv_state_t st1;

    assign bus0.i_psel    = d_psel && (cur == 0);
    assign bus0.i_penable = d_penable;
    assign bus0.i_pwrite  = d_pwrite;
    assign bus0.i_paddr   = d_paddr;
    assign bus0.i_pwdata  = d_pwdata;
    assign bus1.i_psel    = d_psel && (cur == 1);
    assign bus1.i_penable = d_penable;
    assign bus1.i_pwrite  = d_pwrite;
    assign bus1.i_paddr   = d_paddr;
    assign bus1.i_pwdata  = d_pwdata;

    apb_slave_regfile #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(0)
    ) dut0 (
        .i_clk_apb   (clk),
        .i_rst_apb   (rst),
        .apb         (bus0.slave),
        .o_dbg_state (st0)
    );

    apb_slave_regfile #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(3)
    ) dut1 (
        .i_clk_apb   (clk),
        .i_rst_apb   (rst),
        .apb         (bus1.slave),
        .o_dbg_state (st1)
    );

    logic [31:0]    m_prdata;
    logic           m_pready;
    logic           m_pslverr;
    apb_slv_state_t m_state;

    always_comb begin
        m_prdata  = (cur == 1) ? bus1.o_prdata  : bus0.o_prdata;
        m_pready  = (cur == 1) ? bus1.o_pready  : bus0.o_pready;
        m_pslverr = (cur == 1) ? bus1.o_pslverr : bus0.o_pslverr;
        m_state   = (cur == 1) ? st1 : st0;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the completion edge
    // with the bus idle, so consecutive calls are back-to-back.
    task automatic apb_xfer(input int dut, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err, output int cycles);
        int guard;
        cur       = dut;
        d_psel    = 1'b1;
        d_penable = 1'b0;
        d_pwrite  = wr;
        d_paddr   = addr;
        d_pwdata  = wdata;
        cycles    = 1;
        @(posedge clk); #1;
        d_penable = 1'b1;
        cycles    = 2;
        guard     = 0;
        while (!m_pready && guard < 40) begin
            @(posedge clk); #1;
            cycles++;
            guard++;
        end
        check("pready_seen", {31'b0, m_pready}, 32'd1);
        rdata = m_prdata;
        err   = m_pslverr;
        @(posedge clk); #1;
        d_psel    = 1'b0;
        d_penable = 1'b0;
        check("pready_one_cycle", {31'b0, m_pready}, 32'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int          dut;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int dut, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_cycles);
        vec_t v;
        v.dut = dut; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_cycles = exp_cycles;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;

        rst = 1'b1; cur = 0;
        d_psel = 1'b0; d_penable = 1'b0; d_pwrite = 1'b0;
        d_paddr = '0; d_pwdata = '0;

        //       dut wr  addr   wdata          exp_rdata      err cycles
        add_vec(0, 0, 32'h00, 32'h0,          32'h0000_0000, 0, 2);
        add_vec(0, 1, 32'h08, 32'hDEAD_BEEF,  32'h0,         0, 2);
        add_vec(0, 0, 32'h08, 32'h0,          32'hDEAD_BEEF, 0, 2);
        add_vec(1, 0, 32'h04, 32'h0,          32'h0,         0, 5);
        add_vec(0, 1, 32'h40, 32'hA5A5_A5A5,  32'h0,         1, 2);
        add_vec(0, 0, 32'h00, 32'h0,          32'h0,         0, 2);
        add_vec(0, 1, 32'h04, 32'h1111_2222,  32'h0,         0, 2);
        add_vec(0, 0, 32'h06, 32'h0,          32'h0,         1, 2);
        add_vec(0, 0, 32'h04, 32'h0,          32'h1111_2222, 0, 2);
        add_vec(0, 1, 32'h09, 32'h0000_FFFF,  32'h0,         1, 2);
        add_vec(0, 0, 32'h08, 32'h0,          32'hDEAD_BEEF, 0, 2);
        add_vec(0, 1, 32'h00, 32'h0000_1234,  32'h0,         0, 2);
        add_vec(0, 0, 32'h00, 32'h0,          32'h0000_1234, 0, 2);
        add_vec(1, 1, 32'h3C, 32'hCAFE_F00D,  32'h0,         0, 5);
        add_vec(1, 0, 32'h3C, 32'h0,          32'hCAFE_F00D, 0, 5);
        add_vec(0, 0, 32'h3C, 32'h0,          32'h0,         0, 2);
        add_vec(1, 0, 32'h44, 32'h0,          32'h0,         1, 5);

        // Reset and idle-state checks on both instances.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cur = d;
            #1;
            check("rst_prdata",  m_prdata, 32'h0);
            check("rst_pready",  {31'b0, m_pready}, 32'h0);
            check("rst_pslverr", {31'b0, m_pslverr}, 32'h0);
            check("rst_state",   {30'b0, m_state}, {30'b0, ST_IDLE});
        end
        @(posedge clk); #1;

        // Access cycle with no setup must be ignored.
        cur = 0; d_psel = 1'b1; d_penable = 1'b1; d_paddr = 32'h0;
        @(posedge clk); #1;
        check("noset_pready", {31'b0, m_pready}, 32'h0);
        check("noset_state",  {30'b0, m_state}, {30'b0, ST_IDLE});
        d_psel = 1'b0; d_penable = 1'b0;
        @(posedge clk); #1;

        // Table-driven transfers (back-to-back, no idle cycles).
        for (int i = 0; i < vecs.size(); i++) begin
            apb_xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, cyc);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_pslverr", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
        end

        // Abort: drop psel while dut1 is waiting on a write to 0xC.
        apb_xfer(1, 1'b1, 32'h0C, 32'h0000_0055, rd, er, cyc);
        cur = 1; d_psel = 1'b1; d_penable = 1'b0; d_pwrite = 1'b1;
        d_paddr = 32'h0C; d_pwdata = 32'h0000_0077;
        @(posedge clk); #1;
        d_penable = 1'b1;
        @(posedge clk); #1;
        check("abort_in_wait", {30'b0, m_state}, {30'b0, ST_WAIT});
        d_psel = 1'b0; d_penable = 1'b0;
        @(posedge clk); #1;
        check("abort_state",   {30'b0, m_state}, {30'b0, ST_IDLE});
        check("abort_pready",  {31'b0, m_pready}, 32'h0);
        check("abort_pslverr", {31'b0, m_pslverr}, 32'h0);
        check("abort_prdata",  m_prdata, 32'h0);
        apb_xfer(1, 1'b0, 32'h0C, 32'h0, rd, er, cyc);
        check("abort_readback", rd, 32'h0000_0055);

        // Reset in the access cycle of a dut0 write to 0xC.
        cur = 0; d_psel = 1'b1; d_penable = 1'b0; d_pwrite = 1'b1;
        d_paddr = 32'h0C; d_pwdata = 32'h0000_0099;
        @(posedge clk); #1;
        d_penable = 1'b1;
        check("pre_rst_pready", {31'b0, m_pready}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pready", {31'b0, m_pready}, 32'h0);
        check("async_rst_state",  {30'b0, m_state}, {30'b0, ST_IDLE});
        @(posedge clk); #1;
        rst = 1'b0; d_psel = 1'b0; d_penable = 1'b0;
        @(posedge clk); #1;
        apb_xfer(0, 1'b0, 32'h0C, 32'h0, rd, er, cyc);
        check("rst_readback_c", rd, 32'h0);
        apb_xfer(0, 1'b0, 32'h08, 32'h0, rd, er, cyc);
        check("rst_readback_8", rd, 32'h0);
        apb_xfer(1, 1'b0, 32'h0C, 32'h0, rd, er, cyc);
        check("rst_readback_dut1", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
